// File: rtl/rr_grant_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin grant arbiter:
// requester count, index width, FSM encoding and the rotating search.
package rr_grant_arbiter8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic found;
        idx_t idx;
    } pick_t;

    // First set bit of req scanning ptr, ptr+1, ... with wrap modulo 8.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req, input idx_t ptr);
        pick_t p;
        idx_t  cand;
        p = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr + idx_t'(k);
            if (!p.found && req[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/grant_dec3to8.sv
// 3-to-8 one-hot decoder with active-high enable, built from two enabled
// 2-to-4 halves selected by idx[2]; sel[0] is the MSB position.
module grant_dec3to8
    import rr_grant_arbiter8_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [0:N_REQ-1] sel
);

    logic [0:3] lo;
    logic [0:3] hi;

    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        lo = '0;
        hi = '0;
        if (en && !idx[2]) lo[idx[1:0]] = 1'b1;
        if (en &&  idx[2]) hi[idx[1:0]] = 1'b1;
    end

    assign sel = {lo, hi};

endmodule

// File: rtl/rr_grant_arbiter8.sv
// Round-robin arbiter for one resource shared by 8 requesters, with a
// hold-time limit that forces rotation only when someone else is waiting.
module rr_grant_arbiter8
    import rr_grant_arbiter8_pkg::*;
#(
    parameter  int MAX_HOLD = 4,
    localparam int CW       = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       req,
    output logic [0:7]       gnt,
    output logic [2:0]       gnt_idx,
    output logic             gnt_valid
);

    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

    state_t        state;
    idx_t          rr_ptr;
    logic [CW-1:0] hold_cnt;

    logic [N_REQ-1:0] candidates;
    pick_t            pick;
    logic             owner_req;
    logic             take;
    logic             drop;

    // While granted, the owner is masked out so a preemption can never
    // re-select it; on release its request bit is already low anyway.
    always_comb begin
        owner_req  = req[gnt_idx];
        candidates = req;
        if (state == GRANT) candidates = req & ~(N_REQ'(1) << gnt_idx);
        pick = rr_pick(candidates, rr_ptr);
        take = 1'b0;
        drop = 1'b0;
        if (state == IDLE) begin
            take = pick.found;
        end else if (!owner_req) begin
            take = pick.found;
            drop = !pick.found;
        end else if (hold_cnt == HOLD_MAX) begin
            take = pick.found;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            hold_cnt  <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
        end else if (take) begin
            state     <= GRANT;
            gnt_idx   <= pick.idx;
            gnt_valid <= 1'b1;
            hold_cnt  <= CW'(1);
            rr_ptr    <= pick.idx + idx_t'(1);
        end else if (drop) begin
            state     <= IDLE;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
        end else if (state == GRANT && hold_cnt != HOLD_MAX) begin
            hold_cnt  <= hold_cnt + CW'(1);
        end
    end

    grant_dec3to8 u_dec (
        .idx (gnt_idx),
        .en  (gnt_valid),
        .sel (gnt)
    );

endmodule

// File: tb/tb_rr_grant_arbiter8.sv
// Directed self-checking bench for rr_grant_arbiter8 with MAX_HOLD=4;
// expected values are hand-computed from the arbitration rules.
module tb_rr_grant_arbiter8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic [0:7] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    int n_vec = 0;
    int n_err = 0;

    rr_grant_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Grant outputs packed as {valid, idx, gnt} for compact comparisons.
    function automatic logic [31:0] outs();
        return {20'd0, gnt_valid, gnt_idx, gnt};
    endfunction

    function automatic logic [31:0] exp_outs(input int idx);
        logic [0:7] g;
        g = '0;
        g[idx] = 1'b1;
        return {20'd0, 1'b1, 3'(idx), g};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req   = 8'h00;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = 8'h00;
        step();
        step();
        check("reset_outs", outs(), 32'h0);
        check("reset_hold", 32'(dut.hold_cnt), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_no_req", outs(), 32'h0);
        end

        // Release hands over with no idle cycle; 7 wraps the pointer to 0.
        req = 8'h81;
        step();
        check("first_grant0", outs(), exp_outs(0));
        check("first_gnt_bits", 32'(gnt), 32'h80);
        req = 8'h80;
        step();
        check("handover7", outs(), exp_outs(7));
        check("handover7_bits", 32'(gnt), 32'h01);
        check("handover7_hold", 32'(dut.hold_cnt), 32'd1);
        req = 8'h00;
        step();
        check("release_idle", outs(), 32'h0);
        req = 8'h01;
        step();
        check("ptr_wrapped", outs(), exp_outs(0));

        // Full contention: every owner holds exactly MAX_HOLD cycles.
        do_reset();
        req = 8'hFF;
        for (int o = 0; o < 9; o++) begin
            for (int k = 1; k <= 4; k++) begin
                step();
                check($sformatf("rot_o%0d_c%0d", o, k), outs(), exp_outs(o % 8));
                check($sformatf("rot_hold_o%0d_c%0d", o, k), 32'(dut.hold_cnt), 32'(k));
                if (o == 8) break;
            end
        end

        // Lone requester is never preempted; hold counter saturates.
        do_reset();
        req = 8'h08;
        for (int k = 1; k <= 20; k++) begin
            step();
            check($sformatf("solo3_c%0d", k), outs(), exp_outs(3));
            check($sformatf("solo3_hold_c%0d", k), 32'(dut.hold_cnt), 32'(k < 4 ? k : 4));
        end
        check("solo3_bit", 32'(gnt[3]), 32'd1);

        // Reset mid-grant clears everything and restores priority to 0.
        do_reset();
        req = 8'h20;
        step();
        check("own5", outs(), exp_outs(5));
        req   = 8'hFF;
        reset = 1'b1;
        step();
        check("midreset_outs", outs(), 32'h0);
        check("midreset_ptr", 32'(dut.rr_ptr), 32'd0);
        reset = 1'b0;
        step();
        check("after_reset0", outs(), exp_outs(0));

        // Release coinciding with hold expiry is treated as release.
        do_reset();
        req = 8'h04;
        for (int k = 1; k <= 4; k++) step();
        check("own2_at_max", outs(), exp_outs(2));
        check("own2_hold_max", 32'(dut.hold_cnt), 32'd4);
        req = 8'h40;
        step();
        check("rel_at_max6", outs(), exp_outs(6));
        check("rel_at_max_hold", 32'(dut.hold_cnt), 32'd1);

        // Preemption at limit skips the owner and picks next from pointer.
        do_reset();
        req = 8'h02;
        step();
        req = 8'h03;
        for (int k = 2; k <= 4; k++) begin
            step();
            check($sformatf("own1_c%0d", k), outs(), exp_outs(1));
        end
        step();
        check("preempt_to0", outs(), exp_outs(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
